// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply-divide unit; one-cycle MULT/MULTU/MTHI/MTLO, radix-2 restoring DIV/DIVU.
// Owns the architectural HI/LO registers and stalls the pipeline while a divide is in flight.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_hold,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  busy,
  output logic                  stall_request
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_MTHI = 6'h11, F_MTLO = 6'h13;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_hi, r_lo, r_dvd, r_dvs, r_rem;
  logic [CW-1:0] r_cnt;
  logic r_qneg, r_rneg;
  logic w_is_mul, w_is_div, w_a_neg, w_b_neg, w_commit, w_ge, w_start;
  logic [W-1:0] w_a_mag, w_b_mag, w_rem_n, w_q, w_r;
  logic [W:0] w_trial, w_sub;
  logic [2*W-1:0] w_prod;
  assign w_is_mul = (funct == F_MULT) || (funct == F_MULTU);
  assign w_is_div = (funct == F_DIV) || (funct == F_DIVU);
  assign w_a_neg  = (funct == F_DIV) && operand_1[W-1];
  assign w_b_neg  = (funct == F_DIV) && operand_2[W-1];
  assign w_a_mag  = w_a_neg ? -operand_1 : operand_1;
  assign w_b_mag  = w_b_neg ? -operand_2 : operand_2;
  assign w_commit = !flush && !ex_hold;
  assign w_start  = (r_state == IDLE) && w_is_div;
  // Sign- or zero-extend both operands so one 2W-bit product serves MULT and MULTU
  assign w_prod = {{W{(funct == F_MULT) && operand_1[W-1]}}, operand_1} *
                  {{W{(funct == F_MULT) && operand_2[W-1]}}, operand_2};
  assign w_trial = {r_rem, r_dvd[W-1]};
  assign w_sub   = w_trial - {1'b0, r_dvs};
  assign w_ge    = w_trial >= {1'b0, r_dvs};
  assign w_rem_n = w_ge ? w_sub[W-1:0] : w_trial[W-1:0];
  assign w_q     = r_qneg ? -r_dvd : r_dvd;
  assign w_r     = r_rneg ? -r_rem : r_rem;
  assign hi_out  = r_hi;
  assign lo_out  = r_lo;
  always_comb begin
    w_next = r_state;
    if (flush) w_next = IDLE;
    else if (w_start) w_next = RUN;
    else if (r_state == RUN && r_cnt == CW'(W - 1)) w_next = DONE;
    else if (r_state == DONE && !ex_hold) w_next = IDLE;
    busy          = r_state != IDLE;
    stall_request = !rst && (w_start || r_state == RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else begin
      if (w_start) begin
        r_dvd  <= w_a_mag;
        r_dvs  <= w_b_mag;
        r_qneg <= w_a_neg ^ w_b_neg;
        r_rneg <= w_a_neg;
        r_rem  <= '0;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_dvd <= {r_dvd[W-2:0], w_ge};
        r_rem <= w_rem_n;
        r_cnt <= r_cnt + CW'(1);
      end
      // A zero divisor runs the full latency but leaves HI/LO untouched
      if (w_commit) begin
        if (r_state == DONE) begin
          if (r_dvs != '0) begin
            r_lo <= w_q;
            r_hi <= w_r;
          end
        end else if (w_is_mul) {r_hi, r_lo} <= w_prod;
        else if (funct == F_MTHI) r_hi <= operand_1;
        else if (funct == F_MTLO) r_lo <= operand_1;
      end
    end
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

HI/LO multiply–divide unit for the EX stage. Consumes the `funct`, `operand_1` and `operand_2` values delivered by the ID/EX pipeline register and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. It owns the architectural HI and LO registers. Multiplies and moves complete in one cycle. Divides run on an iterative radix-2 restoring divider and raise a stall request to the pipeline controller until the quotient is ready.

## Interface
- DATA_WIDTH, 32, operand/HI/LO width; divide iteration count equals DATA_WIDTH
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  pipeline flush (exception/eret); synchronous abort
- ex_hold  in  1  EX held by a later stage this cycle (excludes this unit's own request)
- funct  in  6  EX operation code from ID/EX; ID recodes non-R-type ops so they never alias the codes below
- operand_1  in  DATA_WIDTH  rs value / dividend / MTHI-MTLO source
- operand_2  in  DATA_WIDTH  rt value / divisor
- hi_out  out  DATA_WIDTH  registered HI
- lo_out  out  DATA_WIDTH  registered LO
- busy  out  1  divider FSM not IDLE
- stall_request  out  1  hold IF..EX this cycle (combinational)

## Operation
- Op codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13. Any other funct means no HI/LO activity.
- Commit condition for any HI/LO write: flush=0 and ex_hold=0 at that edge.
- MULT/MULTU: {HI,LO} <= 64-bit signed/unsigned product at the end of the EX cycle.
- MTHI: HI <= operand_1. MTLO: LO <= operand_1.
- FSM states IDLE, RUN, DONE.
  - IDLE + funct∈{DIV,DIVU}: stall_request=1. At the edge, latch |dividend|, |divisor|, the quotient sign (s1^s2) and the remainder sign (s1), clear partial remainder and count, then go to RUN. For DIVU, magnitudes are the raw values and signs are 0.
  - RUN: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). stall_request=1. After step DATA_WIDTH-1 (count 31), go to DONE.
  - DONE: stall_request=0. When ex_hold=0 at the edge, LO <= signed-corrected quotient, HI <= signed-corrected remainder, and go to IDLE. When ex_hold=1, stay in DONE; HI/LO stay unwritten.
- Signed results: quotient truncates toward zero; remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divisor zero: full latency runs, but no HI/LO write occurs.
- flush=1 at any edge: FSM goes to IDLE, the divide is discarded, and there is no HI/LO write that cycle.
- ex_hold has no effect on the RUN sequence. Divider progress is independent of downstream stalls.

## Timing
- Reset (async): hi_out=0, lo_out=0, state IDLE, busy=0, stall_request=0. Divider datapath is cleared.
- hi_out/lo_out update on the commit edge and are visible from the next cycle.
- DIV occupancy, with DIV entering EX in cycle 0:
  - Cycle 0: IDLE, stall_request=1.
  - Cycles 1–32: RUN, stall_request=1.
  - Cycle 33: DONE, stall_request=0.
  - HI/LO are written at the end of cycle 33, and the next instruction enters EX in cycle 34.
- busy=1 in cycles 1–33.
- The instruction following a divide reads the new HI/LO in its EX cycle (cycle 34). No bypass is needed.
- MULT followed by MFHI: the new HI is visible the next cycle.
- Reset asserted mid-RUN: outputs return immediately to reset values. After release, the unit restarts from IDLE; if DIV is still presented, a fresh 34-cycle sequence begins.
- flush and a DONE commit on the same edge: flush wins, and there is no write.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_request never asserted.
- MULTU 0xFFFFFFFE × 0x00000003 → HI=0x00000002, LO=0xFFFFFFFA. Then MTHI 0x12345678 → HI=0x12345678, LO unchanged.
- DIVU 100 / 7 → stall_request=1 for cycles 0–32, 0 in cycle 33; after that edge LO=14, HI=2, busy=0.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU x / 0 → HI/LO unchanged after 34 cycles.
- DIVU in progress, flush=1 at RUN cycle 10 → state IDLE, stall_request=0 and busy=0 next cycle, HI/LO unchanged.
- DIVU 100 / 7 with ex_hold=1 during cycles 33–35 → DONE held and no write; write occurs at the first edge with ex_hold=0. Async rst pulse in cycle 15 of a divide → immediate hi_out=lo_out=0, busy=0.
